// File: rtl/led_pwm_pio_pkg.sv
// rtl/led_pwm_pio_pkg.sv - register map and limits for the LED PWM PIO
package led_pwm_pio_pkg;

    localparam int MAX_LEDS = 24;

    localparam logic [4:0] ADDR_DATA  = 5'd0;
    localparam logic [4:0] ADDR_MODE  = 5'd1;
    localparam logic [4:0] ADDR_BLINK = 5'd2;
    localparam logic [4:0] ADDR_SET   = 5'd3;
    localparam logic [4:0] ADDR_CLR   = 5'd4;
    localparam logic [4:0] ADDR_FADE  = 5'd5;
    localparam logic [4:0] ADDR_DUTY0 = 5'd8;

endpackage

// File: rtl/led_pwm_pio_if.sv
// rtl/led_pwm_pio_if.sv - Avalon-MM slave bus bundle for the LED PWM PIO
interface led_pwm_pio_if;

    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/led_pwm_chan.sv
// rtl/led_pwm_chan.sv - one LED channel: shadow/active duty, PWM gate, output flop
// Optional ramping of the active duty under LED_PWM_PIO_FADE_EN.
module led_pwm_chan
    import led_pwm_pio_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                pwm_wrap,
    input  logic                data_bit,
    input  logic                mode_bit,
    input  logic                blink_phase,
    output logic [PWM_BITS-1:0] duty_shadow,
    output logic                fading,
    output logic                led
);

    logic [PWM_BITS-1:0] duty_active;
    logic                gate;

    // All-ones duty is a solid on; otherwise a compare that makes duty 0 fully off.
    assign gate   = (duty_active == '1) || (pwm_cnt < duty_active);
    assign fading = (duty_active != duty_shadow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= '1;
            duty_active <= '1;
            led         <= 1'b0;
        end else begin
            if (duty_we) begin
                duty_shadow <= duty_wdata;
            end
            if (pwm_wrap) begin
`ifdef LED_PWM_PIO_FADE_EN
                if (duty_active < duty_shadow) begin
                    duty_active <= duty_active + 1'b1;
                end else if (duty_active > duty_shadow) begin
                    duty_active <= duty_active - 1'b1;
                end
`else
                duty_active <= duty_shadow;
`endif
            end
            led <= data_bit & gate & (~mode_bit | blink_phase);
        end
    end

endmodule

// File: rtl/led_pwm_pio.sv
// rtl/led_pwm_pio.sv - Avalon-MM LED PIO with per-channel on/off, blink and PWM
// Define LED_PWM_PIO_FADE_EN for duty ramping and the FADE status register.
module led_pwm_pio
    import led_pwm_pio_pkg::*;
#(
    parameter int          NUM_LEDS      = 8,
    parameter int          PWM_BITS      = 8,
    parameter int          PRESCALE      = 50,
    parameter logic [15:0] BLINK_DEFAULT = 16'd500
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    led_pwm_pio_if.slave        avs,
    output logic [NUM_LEDS-1:0] led_wire_export
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     presc_cnt;
    logic                tick;
    logic                pwm_wrap;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [15:0]         blink_half;
    logic [15:0]         blink_cnt;
    logic [15:0]         blink_last;
    logic                blink_phase;
    logic [NUM_LEDS-1:0] data_reg;
    logic [NUM_LEDS-1:0] mode_reg;
    logic [NUM_LEDS-1:0] fading;
    logic [NUM_LEDS-1:0] duty_we;
    logic [PWM_BITS-1:0] duty_shadow [NUM_LEDS];
    logic [31:0]         rd_mux;
    logic                wr_blink;
    logic                unused_wdata;

    assign unused_wdata = ^avs.avs_writedata;

    assign tick       = (presc_cnt == PS_W'(PRESCALE - 1));
    assign pwm_wrap   = tick && (pwm_cnt == '1);
    // A half-period of 0 is treated as 1 so the phase still toggles every wrap.
    assign blink_last = (blink_half == 16'd0) ? 16'd0 : blink_half - 16'd1;
    assign wr_blink   = avs.avs_write && (avs.avs_address == ADDR_BLINK);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (wr_blink) begin
                blink_cnt <= '0;
            end else if (pwm_wrap) begin
                if (blink_cnt >= blink_last) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_reg         <= '0;
            mode_reg         <= '0;
            blink_half       <= BLINK_DEFAULT;
            avs.avs_readdata <= '0;
        end else begin
            if (avs.avs_write) begin
                case (avs.avs_address)
                    ADDR_DATA:  data_reg   <= avs.avs_writedata[NUM_LEDS-1:0];
                    ADDR_MODE:  mode_reg   <= avs.avs_writedata[NUM_LEDS-1:0];
                    ADDR_BLINK: blink_half <= avs.avs_writedata[15:0];
                    ADDR_SET:   data_reg   <= data_reg | avs.avs_writedata[NUM_LEDS-1:0];
                    ADDR_CLR:   data_reg   <= data_reg & ~avs.avs_writedata[NUM_LEDS-1:0];
                    default: ;
                endcase
            end
            // Sampled from pre-edge state, so a same-cycle write returns the old value.
            if (avs.avs_read) begin
                avs.avs_readdata <= rd_mux;
            end
        end
    end

    always_comb begin
        duty_we = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_we[i] = avs.avs_write && (avs.avs_address == 5'(ADDR_DUTY0 + i));
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:  rd_mux[NUM_LEDS-1:0] = data_reg;
            ADDR_MODE:  rd_mux[NUM_LEDS-1:0] = mode_reg;
            ADDR_BLINK: rd_mux[15:0]         = blink_half;
`ifdef LED_PWM_PIO_FADE_EN
            ADDR_FADE:  rd_mux[NUM_LEDS-1:0] = fading;
`endif
            default: ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (avs.avs_address == 5'(ADDR_DUTY0 + i)) begin
                rd_mux[PWM_BITS-1:0] = duty_shadow[i];
            end
        end
    end

`ifndef LED_PWM_PIO_FADE_EN
    logic unused_fading;
    assign unused_fading = ^fading;
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk         (clk_clk),
            .rst_n       (reset_reset_n),
            .duty_we     (duty_we[i]),
            .duty_wdata  (avs.avs_writedata[PWM_BITS-1:0]),
            .pwm_cnt     (pwm_cnt),
            .pwm_wrap    (pwm_wrap),
            .data_bit    (data_reg[i]),
            .mode_bit    (mode_reg[i]),
            .blink_phase (blink_phase),
            .duty_shadow (duty_shadow[i]),
            .fading      (fading[i]),
            .led         (led_wire_export[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_pio.sv
// tb/tb_led_pwm_pio.sv - directed self-checking bench for led_pwm_pio
module tb_led_pwm_pio;

    logic       clk;
    logic       rst_n;
    logic [7:0] led_a;
    logic [1:0] led_b;
    int         total;
    int         bad;

    led_pwm_pio_if bus_a ();
    led_pwm_pio_if bus_b ();

    led_pwm_pio #(
        .NUM_LEDS (8),
        .PWM_BITS (8),
        .PRESCALE (2)
    ) u_dut_a (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .avs             (bus_a.slave),
        .led_wire_export (led_a)
    );

    led_pwm_pio #(
        .NUM_LEDS (2),
        .PWM_BITS (2),
        .PRESCALE (1)
    ) u_dut_b (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .avs             (bus_b.slave),
        .led_wire_export (led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input bit sel, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel) begin
            bus_b.avs_address = a; bus_b.avs_writedata = d; bus_b.avs_write = 1'b1;
        end else begin
            bus_a.avs_address = a; bus_a.avs_writedata = d; bus_a.avs_write = 1'b1;
        end
        @(negedge clk);
        bus_a.avs_write = 1'b0;
        bus_b.avs_write = 1'b0;
    endtask

    task automatic bus_read(input bit sel, input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        if (sel) begin
            bus_b.avs_address = a; bus_b.avs_read = 1'b1;
        end else begin
            bus_a.avs_address = a; bus_a.avs_read = 1'b1;
        end
        @(negedge clk);
        bus_a.avs_read = 1'b0;
        bus_b.avs_read = 1'b0;
        d = sel ? bus_b.avs_readdata : bus_a.avs_readdata;
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (led_a[0]) c++;
        end
    endtask

    task automatic wait_rise(input int limit, output bit ok);
        logic prev;
        prev = led_a[0];
        ok   = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!prev && led_a[0]) begin
                ok = 1'b1;
                break;
            end
            prev = led_a[0];
        end
    endtask

    task automatic wait_toggle(input int limit, output int cycles);
        logic prev;
        prev   = led_b[0];
        cycles = limit;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (led_b[0] != prev) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic reset_reads(input string pfx);
        logic [31:0] d;
        bus_read(1'b0, 5'd8, d);  chk({pfx, "_duty0"}, d, 32'hFF);
        bus_read(1'b0, 5'd2, d);  chk({pfx, "_blink_half"}, d, 32'd500);
        bus_read(1'b0, 5'd0, d);  chk({pfx, "_data"}, d, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        int          c;
        int          run;
        bit          ok;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_a.avs_address = '0; bus_a.avs_read = 1'b0; bus_a.avs_write = 1'b0; bus_a.avs_writedata = '0;
        bus_b.avs_address = '0; bus_b.avs_read = 1'b0; bus_b.avs_write = 1'b0; bus_b.avs_writedata = '0;

        repeat (3) @(negedge clk);
        chk("reset_led", {24'h0, led_a}, 32'h0);
        rst_n = 1'b1;
        reset_reads("rst");

        // Static on, set and clear
        bus_write(1'b0, 5'd0, 32'hA5);
        chk("data_latency", {24'h0, led_a}, 32'h00);
        @(negedge clk);
        chk("data_a5", {24'h0, led_a}, 32'hA5);
        repeat (20) @(negedge clk);
        chk("data_a5_steady", {24'h0, led_a}, 32'hA5);
        bus_write(1'b0, 5'd3, 32'h02);
        @(negedge clk);
        chk("set_02", {24'h0, led_a}, 32'hA7);
        bus_write(1'b0, 5'd4, 32'h80);
        @(negedge clk);
        chk("clr_80", {24'h0, led_a}, 32'h27);
        bus_read(1'b0, 5'd3, d);
        chk("set_reads_0", d, 32'h0);

        // 25% duty: 64 of 256 counts at 2 clocks per count
        bus_write(1'b0, 5'd0, 32'h01);
        bus_write(1'b0, 5'd8, 32'd64);
        repeat (600) @(negedge clk);
        count_high(512, c);
        chk("pwm25_high", c, 128);

        // Duty change mid-period keeps the current period intact
        wait_rise(1100, ok);
        chk("glitch_sync", {31'h0, ok}, 32'h1);
        run = 1;
        for (int k = 0; k < 1000; k++) begin
            if (run == 20) begin
                bus_a.avs_address = 5'd8; bus_a.avs_writedata = 32'd192; bus_a.avs_write = 1'b1;
            end else begin
                bus_a.avs_write = 1'b0;
            end
            @(negedge clk);
            if (!led_a[0]) break;
            run++;
        end
        bus_a.avs_write = 1'b0;
        chk("glitch_old_period", run, 128);
        wait_rise(1100, ok);
        chk("glitch_sync2", {31'h0, ok}, 32'h1);
        run = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!led_a[0]) break;
            run++;
        end
        chk("glitch_new_period", run, 384);

        bus_write(1'b0, 5'd8, 32'd0);
        repeat (600) @(negedge clk);
        count_high(1024, c);
        chk("duty0_off", c, 0);

        // Blink: one PWM period is 4 clocks, 3 periods per half-phase
        bus_write(1'b1, 5'd2, 32'd3);
        bus_write(1'b1, 5'd1, 32'h1);
        bus_write(1'b1, 5'd0, 32'h1);
        bus_write(1'b1, 5'd8, 32'd3);
        repeat (30) @(negedge clk);
        wait_toggle(60, c);
        chk("blink_sync", {31'h0, c < 60}, 32'h1);
        wait_toggle(60, c);
        chk("blink_half1", c, 12);
        wait_toggle(60, c);
        chk("blink_half2", c, 12);

        // Bus edges
        bus_read(1'b0, 5'd7, d);   chk("read_addr7", d, 32'h0);
        bus_read(1'b0, 5'd31, d);  chk("read_addr31", d, 32'h0);
        bus_write(1'b0, 5'd16, 32'h12);
        bus_read(1'b0, 5'd15, d);  chk("duty7_untouched", d, 32'hFF);
        bus_read(1'b0, 5'd16, d);  chk("read_addr16", d, 32'h0);
        bus_write(1'b0, 5'd9, 32'h1AB);
        bus_read(1'b0, 5'd9, d);   chk("duty1_width", d, 32'hAB);
        @(negedge clk);
        bus_a.avs_address = 5'd0; bus_a.avs_writedata = 32'h5B;
        bus_a.avs_read = 1'b1; bus_a.avs_write = 1'b1;
        @(negedge clk);
        bus_a.avs_read = 1'b0; bus_a.avs_write = 1'b0;
        chk("rw_old_value", bus_a.avs_readdata, 32'h01);
        bus_read(1'b0, 5'd0, d);   chk("rw_new_value", d, 32'h5B);

        // Fade status on channel 2 (still at all-ones from reset)
        bus_write(1'b0, 5'd10, 32'd250);
`ifdef LED_PWM_PIO_FADE_EN
        bus_read(1'b0, 5'd5, d);   chk("fade_busy_start", d, 32'h04);
        repeat (3 * 512) @(negedge clk);
        bus_read(1'b0, 5'd5, d);   chk("fade_busy_mid", d, 32'h04);
        repeat (3 * 512) @(negedge clk);
        bus_read(1'b0, 5'd5, d);   chk("fade_done", d, 32'h0);
`else
        bus_read(1'b0, 5'd5, d);   chk("fade_reads_0", d, 32'h0);
`endif

        // Asynchronous reset mid-run
        bus_write(1'b0, 5'd0, 32'hF0);
        @(negedge clk);
        chk("pre_reset_led", {24'h0, led_a}, 32'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_led_a", {24'h0, led_a}, 32'h0);
        chk("async_reset_led_b", {30'h0, led_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_reads("rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
